// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, small-sigma functions,
// sequencer state encoding and word/index widths.
package sha256_pkg;

  localparam int WORD_W = 32;
  localparam int IDX_W  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_FOLD,
    ST_DONE
  } seq_state_t;

  localparam logic [WORD_W-1:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_sched_window.sv
// Sliding 16-word message schedule window. Word 0 is the current W_t;
// every accepted round shifts the window down and appends the next W.
module sha256_sched_window
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [511:0]      block,
  input  logic              shift,
  output logic [WORD_W-1:0] w0
);

  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] next_word;

  assign next_word = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
  assign w0        = win_q[0];

  // Parallel load of a fresh block, otherwise shift-and-expand on each accepted round
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win_q[i] <= block[511-32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
      win_q[15] <= next_word;
    end
  end

endmodule

// File: rtl/sha256_round_sequencer.sv
// Sequences a shared single-round SHA-256 datapath over a two-block message
// with a valid/ready round handshake, plus init/fold/done strobes.
// Optional feature macro: SHA_SEQ_STALL_CNT_EN builds the backpressure
// stall counter; without it stall_cycles is tied to zero.
module sha256_round_sequencer
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64,
  parameter int BLOCKS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1023:0]     message,
  output logic              busy,
  output logic              done,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic [IDX_W-1:0]  rnd_idx,
  output logic              rnd_blk,
  output logic [WORD_W-1:0] rnd_k,
  output logic [WORD_W-1:0] rnd_w,
  output logic              rnd_init,
  output logic              fold,
  output logic [15:0]       stall_cycles
);

  localparam logic [IDX_W-1:0] LAST_T   = IDX_W'(ROUNDS - 1);
  localparam logic             LAST_BLK = 1'(BLOCKS - 1);

  seq_state_t        state_q, state_d;
  logic [1023:0]     msg_q;
  logic              blk_q;
  logic [IDX_W-1:0]  t_q;
  logic [WORD_W-1:0] win_w0;
  logic [511:0]      load_block;
  logic              win_load;
  logic              win_shift;

  assign load_block = blk_q ? msg_q[511:0] : msg_q[1023:512];
  assign win_load   = (state_q == ST_LOAD);
  assign win_shift  = (state_q == ST_ROUND) && rnd_ready;

  sha256_sched_window u_window (
    .clk   (clk),
    .rst   (rst),
    .load  (win_load),
    .block (load_block),
    .shift (win_shift),
    .w0    (win_w0)
  );

  // State register plus message latch, block index and round counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      msg_q   <= '0;
      blk_q   <= 1'b0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE:  if (start) begin
                    msg_q <= message;
                    blk_q <= 1'b0;
                  end
        ST_LOAD:  t_q <= '0;
        ST_ROUND: if (rnd_ready) t_q <= t_q + 1'b1;
        ST_FOLD:  if (blk_q != LAST_BLK) blk_q <= blk_q + 1'b1;
        default:  ;
      endcase
    end
  end

  // Next state and outputs; outputs depend only on registered state so rnd_* never follow rnd_ready
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    fold      = 1'b0;
    rnd_valid = 1'b0;
    rnd_idx   = '0;
    rnd_blk   = 1'b0;
    rnd_k     = '0;
    rnd_w     = '0;
    rnd_init  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        busy    = 1'b1;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        busy      = 1'b1;
        rnd_valid = 1'b1;
        rnd_idx   = t_q;
        rnd_blk   = blk_q;
        rnd_k     = K_TABLE[t_q];
        rnd_w     = win_w0;
        rnd_init  = (blk_q == 1'b0) && (t_q == '0);
        if (rnd_ready && (t_q == LAST_T)) state_d = ST_FOLD;
      end
      ST_FOLD: begin
        busy    = 1'b1;
        fold    = 1'b1;
        state_d = (blk_q == LAST_BLK) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SHA_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of stalled round cycles, cleared when a new hash is accepted
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      stall_q <= '0;
    end else if ((state_q == ST_ROUND) && !rnd_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
